// File: rtl/serdes_encrypt_scheduler_if.sv
// Request, serial-encryptor and response signals of the encrypt scheduler.
// The slave modport is the scheduler side; the master modport is the environment side.
interface serdes_encrypt_scheduler_if;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [7:0] req0_a;
  logic [7:0] req0_b;
  logic [7:0] req1_a;
  logic [7:0] req1_b;
  logic       enc_start;
  logic       enc_a_bit;
  logic       enc_b_bit;
  logic [7:0] enc_cipher;
  logic       enc_done;
  logic       resp_valid;
  logic       resp_id;
  logic [7:0] resp_data;
  logic       resp_err;
  logic       resp_ready;
  logic       busy;

  modport slave (
    input  req_valid, req0_a, req0_b, req1_a, req1_b, enc_cipher, enc_done, resp_ready,
    output req_ready, enc_start, enc_a_bit, enc_b_bit, resp_valid, resp_id, resp_data,
           resp_err, busy
  );

  modport master (
    output req_valid, req0_a, req0_b, req1_a, req1_b, enc_cipher, enc_done, resp_ready,
    input  req_ready, enc_start, enc_a_bit, enc_b_bit, resp_valid, resp_id, resp_data,
           resp_err, busy
  );
endinterface

// File: rtl/serdes_encrypt_scheduler.sv
// Round-robin job scheduler for the bit-serial encryptor: start pulse, 8-bit MSB-first
// shift of plaintext/key, done wait with timeout, then a held valid/ready response.
module serdes_encrypt_scheduler #(
  parameter int TIMEOUT = 32
) (
  input logic                        clk,
  input logic                        rst,
  serdes_encrypt_scheduler_if.slave  bus
);

  localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, START, SHIFT, WAIT, RESP} state_t;

  state_t     r_state;
  state_t     w_next;
  logic       w_accept;
  logic       w_grant;
  logic [1:0] w_reqReady;

  logic       r_prio;
  logic       r_id;
  logic [7:0] r_a;
  logic [7:0] r_b;
  logic [2:0] r_idx;
  logic [7:0] r_cnt;
  logic [7:0] r_data;
  logic       r_err;
  logic       r_start;
  logic       r_aBit;
  logic       r_bBit;
  logic       r_respValid;
  logic       r_busy;

  // Reset gates acceptance so a request seen alongside reset is never taken.
  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_grant    = 1'b0;
    w_reqReady = 2'b00;
    case (r_state)
      IDLE: begin
        if (!rst && (|bus.req_valid)) begin
          w_accept   = 1'b1;
          w_grant    = (&bus.req_valid) ? r_prio : bus.req_valid[1];
          w_reqReady = w_grant ? 2'b10 : 2'b01;
          w_next     = START;
        end
      end
      START: w_next = SHIFT;
      SHIFT: begin
        if (r_idx == 3'd0) w_next = WAIT;
      end
      WAIT: begin
        if (bus.enc_done || (r_cnt == LP_TIMEOUT)) w_next = RESP;
      end
      RESP: begin
        if (bus.resp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_prio      <= 1'b0;
      r_id        <= 1'b0;
      r_a         <= 8'h00;
      r_b         <= 8'h00;
      r_idx       <= 3'd0;
      r_cnt       <= 8'h00;
      r_data      <= 8'h00;
      r_err       <= 1'b0;
      r_start     <= 1'b0;
      r_aBit      <= 1'b0;
      r_bBit      <= 1'b0;
      r_respValid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_start     <= (w_next == START);
      r_respValid <= (w_next == RESP);
      r_busy      <= (w_next != IDLE);
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a    <= w_grant ? bus.req1_a : bus.req0_a;
            r_b    <= w_grant ? bus.req1_b : bus.req0_b;
            r_id   <= w_grant;
            r_prio <= ~w_grant;
          end
        end
        START: begin
          r_idx  <= 3'd7;
          r_aBit <= r_a[7];
          r_bBit <= r_b[7];
        end
        SHIFT: begin
          if (r_idx == 3'd0) begin
            r_aBit <= 1'b0;
            r_bBit <= 1'b0;
            r_cnt  <= 8'h00;
          end else begin
            r_idx  <= r_idx - 3'd1;
            r_aBit <= r_a[r_idx - 3'd1];
            r_bBit <= r_b[r_idx - 3'd1];
          end
        end
        WAIT: begin
          // A done arriving on the timeout cycle still counts as success.
          if (bus.enc_done) begin
            r_data <= bus.enc_cipher;
            r_err  <= 1'b0;
          end else if (r_cnt == LP_TIMEOUT) begin
            r_data <= 8'h00;
            r_err  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'h01;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready  = w_reqReady;
  assign bus.enc_start  = r_start;
  assign bus.enc_a_bit  = r_aBit;
  assign bus.enc_b_bit  = r_bBit;
  assign bus.resp_valid = r_respValid;
  assign bus.resp_id    = r_id;
  assign bus.resp_data  = r_data;
  assign bus.resp_err   = r_err;
  assign bus.busy       = r_busy;

endmodule

// File: tb/tb_serdes_encrypt_scheduler.sv
// Directed bench for serdes_encrypt_scheduler: single job, round-robin, timeout,
// back-pressure, reset mid-shift and a spurious done during SHIFT.
module tb_serdes_encrypt_scheduler;

  localparam int TIMEOUT = 32;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  serdes_encrypt_scheduler_if ifc ();

  serdes_encrypt_scheduler #(.TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, ".req_ready"}, ifc.req_ready, 2'b00);
    checkOutput({tag, ".enc_start"}, ifc.enc_start, 1'b0);
    checkOutput({tag, ".a_bit"}, ifc.enc_a_bit, 1'b0);
    checkOutput({tag, ".b_bit"}, ifc.enc_b_bit, 1'b0);
    checkOutput({tag, ".resp_valid"}, ifc.resp_valid, 1'b0);
    checkOutput({tag, ".busy"}, ifc.busy, 1'b0);
  endtask

  // Reset is held for one edge while validDuringReset is offered; nothing may be taken.
  task automatic applyReset(input logic [1:0] validDuringReset);
    @(negedge clk);
    rst = 1'b1;
    ifc.req_valid = validDuringReset;
    @(negedge clk);
    rst = 1'b0;
    ifc.req_valid = 2'b00;
    #1;
    checkIdleOutputs("reset");
    checkOutput("reset.resp_id", ifc.resp_id, 1'b0);
    checkOutput("reset.resp_data", ifc.resp_data, 8'h00);
    checkOutput("reset.resp_err", ifc.resp_err, 1'b0);
  endtask

  // Starts at a negedge in IDLE; ends at the first negedge with resp_valid expected high.
  // doneDelay < 0 means the core never answers.
  task automatic applyStimulus(input logic [1:0] valid, input logic expId,
                               input logic [7:0] a0, input logic [7:0] b0,
                               input logic [7:0] a1, input logic [7:0] b1,
                               input int doneDelay, input logic [7:0] cipher,
                               input logic keepValid, input logic spurious, input string tag);
    logic [7:0] aBits;
    logic [7:0] bBits;
    int waitCycles;
    aBits = 8'h00;
    bBits = 8'h00;
    ifc.req0_a = a0;
    ifc.req0_b = b0;
    ifc.req1_a = a1;
    ifc.req1_b = b1;
    ifc.req_valid = valid;
    #1;
    checkOutput({tag, ".grant"}, ifc.req_ready, expId ? 2'b10 : 2'b01);
    @(negedge clk);
    if (!keepValid) ifc.req_valid = 2'b00;
    checkOutput({tag, ".start"}, ifc.enc_start, 1'b1);
    checkOutput({tag, ".busy"}, ifc.busy, 1'b1);
    if (keepValid) checkOutput({tag, ".ready_off"}, ifc.req_ready, 2'b00);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      aBits = {aBits[6:0], ifc.enc_a_bit};
      bBits = {bBits[6:0], ifc.enc_b_bit};
      if (i == 0) checkOutput({tag, ".start_pulse"}, ifc.enc_start, 1'b0);
      if (spurious && i == 3) begin
        ifc.enc_done = 1'b1;
        ifc.enc_cipher = 8'h11;
      end else if (spurious && i == 4) begin
        ifc.enc_done = 1'b0;
        ifc.enc_cipher = 8'h00;
      end
    end
    checkOutput({tag, ".a_bits"}, aBits, expId ? a1 : a0);
    checkOutput({tag, ".b_bits"}, bBits, expId ? b1 : b0);
    @(negedge clk);
    checkOutput({tag, ".wait_bits"}, {ifc.enc_a_bit, ifc.enc_b_bit}, 2'b00);
    if (doneDelay >= 0) begin
      repeat (doneDelay) @(negedge clk);
      checkOutput({tag, ".no_early_resp"}, ifc.resp_valid, 1'b0);
      ifc.enc_done = 1'b1;
      ifc.enc_cipher = cipher;
      @(negedge clk);
      ifc.enc_done = 1'b0;
      ifc.enc_cipher = 8'h00;
      checkOutput({tag, ".resp_valid"}, ifc.resp_valid, 1'b1);
    end else begin
      waitCycles = 0;
      while (!ifc.resp_valid && waitCycles < 100) begin
        @(negedge clk);
        waitCycles++;
      end
      checkOutput({tag, ".timeout_cycles"}, waitCycles, TIMEOUT + 1);
    end
  endtask

  // Holds resp_ready low for holdCycles while checking stability, then handshakes.
  task automatic finishResp(input logic expId, input logic [7:0] expData, input logic expErr,
                            input int holdCycles, input string tag);
    checkOutput({tag, ".resp"}, {ifc.resp_valid, ifc.resp_id, ifc.resp_data, ifc.resp_err},
                {1'b1, expId, expData, expErr});
    for (int h = 0; h < holdCycles; h++) begin
      @(negedge clk);
      checkOutput({tag, ".hold"},
                  {ifc.resp_valid, ifc.resp_id, ifc.resp_data, ifc.resp_err, ifc.req_ready},
                  {1'b1, expId, expData, expErr, 2'b00});
    end
    ifc.resp_ready = 1'b1;
    @(negedge clk);
    ifc.resp_ready = 1'b0;
    checkOutput({tag, ".consumed"}, {ifc.resp_valid, ifc.busy}, 2'b00);
  endtask

  logic [7:0] rrCipher [4] = '{8'h5A, 8'hA5, 8'h0F, 8'hF0};
  int respSeen;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    ifc.req_valid = 2'b00;
    ifc.req0_a = 8'h00;
    ifc.req0_b = 8'h00;
    ifc.req1_a = 8'h00;
    ifc.req1_b = 8'h00;
    ifc.enc_cipher = 8'h00;
    ifc.enc_done = 1'b0;
    ifc.resp_ready = 1'b0;

    applyReset(2'b01);
    @(negedge clk);
    checkOutput("reset_vs_valid.busy", ifc.busy, 1'b0);

    // Single job, core answers 3 cycles after bit 0
    applyStimulus(2'b01, 1'b0, 8'h02, 8'h03, 8'h00, 8'h00, 2, 8'hA4, 1'b0, 1'b0, "single");
    finishResp(1'b0, 8'hA4, 1'b0, 0, "single");

    // Round-robin with both requesters held valid
    applyReset(2'b00);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(2'b11, k[0], 8'h3C, 8'hC3, 8'h96, 8'h69, 1, rrCipher[k], 1'b1, 1'b0, "rr");
      finishResp(k[0], rrCipher[k], 1'b0, 1, "rr");
    end
    ifc.req_valid = 2'b00;

    // Timeout, then a normal job
    applyStimulus(2'b10, 1'b1, 8'h00, 8'h00, 8'h81, 8'h7E, -1, 8'h00, 1'b0, 1'b0, "timeout");
    finishResp(1'b1, 8'h00, 1'b1, 0, "timeout");
    applyStimulus(2'b01, 1'b0, 8'hE7, 8'h18, 8'h00, 8'h00, 0, 8'h3C, 1'b0, 1'b0, "after_to");
    finishResp(1'b0, 8'h3C, 1'b0, 0, "after_to");

    // Back-pressure with req1 waiting
    applyStimulus(2'b01, 1'b0, 8'h55, 8'hAA, 8'h12, 8'h34, 4, 8'hC5, 1'b0, 1'b0, "bp");
    ifc.req_valid = 2'b10;
    finishResp(1'b0, 8'hC5, 1'b0, 10, "bp");
    applyStimulus(2'b10, 1'b1, 8'h55, 8'hAA, 8'h12, 8'h34, 2, 8'h77, 1'b0, 1'b0, "bp_next");
    finishResp(1'b1, 8'h77, 1'b0, 0, "bp_next");

    // Reset while shifting bit 4 of a req0 job
    ifc.req0_a = 8'hFF;
    ifc.req0_b = 8'hFF;
    ifc.req_valid = 2'b01;
    @(negedge clk);
    ifc.req_valid = 2'b00;
    repeat (4) @(negedge clk);
    checkOutput("midrst.bit4", {ifc.enc_a_bit, ifc.enc_b_bit}, 2'b11);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkIdleOutputs("midrst");
    respSeen = 0;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      if (c == 10) ifc.enc_done = 1'b1;
      if (c == 11) ifc.enc_done = 1'b0;
      if (ifc.resp_valid) respSeen++;
    end
    checkOutput("midrst.no_resp", respSeen, 0);
    applyStimulus(2'b11, 1'b0, 8'hA1, 8'h1A, 8'hB2, 8'h2B, 1, 8'h99, 1'b0, 1'b0, "post_rst");
    finishResp(1'b0, 8'h99, 1'b0, 0, "post_rst");

    // Spurious done during SHIFT, real done in WAIT
    applyStimulus(2'b01, 1'b0, 8'hC9, 8'h36, 8'h00, 8'h00, 1, 8'h5A, 1'b0, 1'b1, "spurious");
    finishResp(1'b0, 8'h5A, 1'b0, 0, "spurious");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serdes_encrypt_scheduler.md
# serdes_encrypt_scheduler

Sequencing and arbitration controller for the bit-serial encryptor core. It accepts 8-bit plaintext/key byte pairs from two requesters and grants them round-robin. For each granted job it issues the one-cycle start pulse and shifts both bytes MSB-first on `a_bit`/`b_bit` for 8 cycles. It then waits for the core's done, with a timeout, and returns the cipher byte to the originating requester over a valid/ready response channel.

## Interface
Parameters:
- `TIMEOUT`, 32: maximum cycles spent in WAIT before an error response (range 1–255).

Ports:
- `clk` input 1: single clock; all logic on its rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `req_valid` input 2: bit i = requester i has a job pending.
- `req_ready` output 2: bit i = job from requester i is accepted this cycle.
- `req0_a`, `req0_b` input 8 each: requester 0 plaintext and key bytes.
- `req1_a`, `req1_b` input 8 each: requester 1 plaintext and key bytes.
- `enc_start` output 1: one-cycle start pulse to the encryptor core.
- `enc_a_bit`, `enc_b_bit` output 1 each: serial data/key bits, MSB first.
- `enc_cipher` input 8: cipher byte from the core, sampled when `enc_done` is high.
- `enc_done` input 1: core completion pulse.
- `resp_valid` output 1: response available.
- `resp_id` output 1: requester the response belongs to.
- `resp_data` output 8: cipher byte; 0 on error.
- `resp_err` output 1: response is a timeout error.
- `resp_ready` input 1: consumer accepts the response.
- `busy` output 1: high in any state other than IDLE.

## Operation
- States: IDLE, START, SHIFT, WAIT, RESP.
- **IDLE**
  - The arbiter picks among `req_valid` using round-robin pointer `prio` (reset 0).
    - If both requesters are valid, grant `prio`.
    - If only one is valid, grant that one.
  - `req_ready[g]` is combinational, driven only in IDLE, for the granted index only.
  - On the accept edge:
    - latch `a`/`b` into shift registers;
    - latch `id = g`;
    - set `prio = ~g`;
    - go to START.
- **START**
  - `enc_start = 1` for exactly one cycle.
  - Go to SHIFT with bit index = 7.
- **SHIFT**
  - `enc_a_bit = a[idx]` and `enc_b_bit = b[idx]`; 8 cycles, idx 7 down to 0.
  - After idx 0, go to WAIT and clear the timeout counter.
- **WAIT**
  - If `enc_done` is high: capture `enc_cipher` into `resp_data`, set `resp_err = 0`, go to RESP.
  - Otherwise increment the counter. When the counter reaches `TIMEOUT`: set `resp_data = 0`, `resp_err = 1`, go to RESP.
- **RESP**
  - `resp_valid = 1`; `resp_id`, `resp_data` and `resp_err` are held stable.
  - When `resp_valid & resp_ready`, go to IDLE.
- `enc_done` in IDLE, START, SHIFT or RESP is ignored: no capture, no state change.
- No new job is accepted until the response handshake completes. There is no overlap.
- `enc_a_bit`, `enc_b_bit` and `enc_start` are 0 outside SHIFT/START respectively.

## Timing
- Reset values:
  - state IDLE, `prio` 0;
  - `req_ready` 0 (no valid inputs), `enc_start` 0, `enc_a_bit` 0, `enc_b_bit` 0;
  - `resp_valid` 0, `resp_id` 0, `resp_data` 0, `resp_err` 0, `busy` 0.
- Reset mid-operation, in any state: returns to IDLE next edge. Any in-flight job is dropped with no response, and `prio` returns to 0.
- All outputs except `req_ready` are registered.
- Latency, with the accept edge at cycle T:
  - `enc_start` high during cycle T+1;
  - bit 7 during T+2 through bit 0 during T+9;
  - WAIT begins at T+10.
  - `enc_done` sampled high at edge D gives `resp_valid` from D+1.
  - A timeout gives `resp_valid` exactly `TIMEOUT`+1 cycles after WAIT entry.
- `enc_done` high in the same cycle the counter hits `TIMEOUT`: done wins (no error).
- `resp_ready` high while `resp_valid` is high: response consumed that edge. The earliest next accept is the following cycle, from IDLE.
- `rst` asserted together with `req_valid`: reset wins, nothing is accepted.

## Test plan
- **Single job:** req0 valid with a=0x02, b=0x03 and the core model returning done 3 cycles after bit 0.
  - `enc_start` is a 1-cycle pulse.
  - `a_bit` sequence 0,0,0,0,0,0,1,0; `b_bit` sequence 0,0,0,0,0,0,1,1.
  - `resp_valid` with id=0, data = model cipher, err=0.
- **Round-robin:** both requesters held valid continuously for 4 jobs.
  - Grant order is 0,1,0,1.
  - Each `resp_id` matches its grant and `req_ready` is one-hot, one cycle per job.
- **Timeout:** core never asserts done, `TIMEOUT`=32.
  - `resp_valid` exactly 33 cycles after WAIT entry, with err=1, data=0x00.
  - Next job proceeds normally.
- **Back-pressure:** `resp_ready` held low 10 cycles.
  - `resp_valid`, `resp_data` and `resp_id` are stable throughout.
  - `req_ready` stays 0 while req1 is valid, until the handshake.
- **Reset mid-SHIFT:** `rst` pulsed at idx=4.
  - All outputs reach their reset values next cycle and no response is issued.
  - A fresh job afterwards completes correctly starting from `prio`=0.
- **Spurious done:** `enc_done` pulsed during SHIFT, then the real done in WAIT.
  - Only the WAIT-cycle `enc_cipher` value is returned.
